// File: rtl/core_pkg.sv
// Shared types and constants for the write-back stage.
//   ld_size_t    : load access size (byte, half, word, dword)
//   SRC_*        : result source indices used by the write-back mux
//   XLEN_DEFAULT : default datapath width
package core_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_t;

  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_CSR  = 2;

  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/write_back_stage_if.sv
// MEM -> WB handshake bundle.
//   master : memory stage (drives the instruction, receives ready_o)
//   slave  : write-back stage (consumes the instruction, drives ready_o)
//   valid_i / ready_o          : transfer handshake
//   src_data_i / src_sel_i     : packed result sources and select
//   reg_write_i / rd_i         : destination write request
//   ld_size_i / ld_unsigned_i / ld_addr_lo_i : load formatting controls
interface write_back_stage_if
  import core_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int NUM_SRC = 4,
  parameter int RA_W    = 5
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic                    valid_i;
  logic                    ready_o;
  logic [NUM_SRC*XLEN-1:0] src_data_i;
  logic [SEL_W-1:0]        src_sel_i;
  logic                    reg_write_i;
  logic [RA_W-1:0]         rd_i;
  ld_size_t                ld_size_i;
  logic                    ld_unsigned_i;
  logic [2:0]              ld_addr_lo_i;

  modport master (
    output valid_i, src_data_i, src_sel_i, reg_write_i, rd_i,
           ld_size_i, ld_unsigned_i, ld_addr_lo_i,
    input  ready_o
  );

  modport slave (
    input  valid_i, src_data_i, src_sel_i, reg_write_i, rd_i,
           ld_size_i, ld_unsigned_i, ld_addr_lo_i,
    output ready_o
  );

endinterface

// File: rtl/load_align_ext.sv
// Combinational load formatter: shifts the raw memory word down to the
// addressed byte lane, extracts the access size and sign/zero extends it.
//   word        : raw load word
//   addr_lo     : low address bits (only [1:0] matter when XLEN=32)
//   size        : access size
//   is_unsigned : zero-extend instead of sign-extend
//   data        : formatted result
//   misaligned  : access not naturally aligned for its size
module load_align_ext
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      addr_lo,
  input  ld_size_t        size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;

  assign shamt   = (XLEN == 32) ? {1'b0, addr_lo[1:0], 3'b000} : {addr_lo, 3'b000};
  assign shifted = word >> shamt;

  // Size casts of a signed operand sign-extend, of an unsigned one zero-extend.
  always_comb begin
    data = shifted;
    unique case (size)
      LD_B: data = is_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      LD_H: data = is_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      LD_W: data = is_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      LD_D: data = shifted;
      default: data = shifted;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (size)
      LD_B: misaligned = 1'b0;
      LD_H: misaligned = addr_lo[0];
      LD_W: misaligned = |addr_lo[1:0];
      LD_D: misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// Registered write-back stage: captures the MEM/WB instruction, selects the
// result, drives the register-file write port and the forwarding bus, and
// counts retired instructions.
//   clk, rst_n       : clock, synchronous active-low reset
//   mem              : MEM -> WB handshake bundle (slave side)
//   flush_i, stall_i : kill / hold the registered instruction
//   result_o         : selected result
//   rf_a3_o, rf_wd3_o, rf_we_o        : register-file write port
//   fwd_valid_o, fwd_rd_o, fwd_data_o : forwarding bus
//   misaligned_o     : misaligned load indication
//   instret_o        : retired-instruction count
module write_back_stage
  import core_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_SRC  = 4,
  parameter int LOAD_SRC = SRC_LOAD,
  parameter int RA_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  write_back_stage_if.slave   mem,
  input  logic                flush_i,
  input  logic                stall_i,
  output logic [XLEN-1:0]     result_o,
  output logic [RA_W-1:0]     rf_a3_o,
  output logic [XLEN-1:0]     rf_wd3_o,
  output logic                rf_we_o,
  output logic                fwd_valid_o,
  output logic [RA_W-1:0]     fwd_rd_o,
  output logic [XLEN-1:0]     fwd_data_o,
  output logic                misaligned_o,
  output logic [63:0]         instret_o
);

  localparam int SEL_W = $clog2(NUM_SRC);

  logic                    valid_q;
  logic [NUM_SRC*XLEN-1:0] src_data_q;
  logic [SEL_W-1:0]        src_sel_q;
  logic                    reg_write_q;
  logic [RA_W-1:0]         rd_q;
  ld_size_t                ld_size_q;
  logic                    ld_unsigned_q;
  logic [2:0]              ld_addr_lo_q;
  logic [63:0]             instret_q;

  logic [XLEN-1:0] ld_data;
  logic            ld_misaligned;
  logic            misaligned;
  logic            retire;
  logic [XLEN-1:0] result;

  assign mem.ready_o = !stall_i;

  load_align_ext #(.XLEN(XLEN)) u_load_align_ext (
    .word        (src_data_q[LOAD_SRC*XLEN +: XLEN]),
    .addr_lo     (ld_addr_lo_q),
    .size        (ld_size_q),
    .is_unsigned (ld_unsigned_q),
    .data        (ld_data),
    .misaligned  (ld_misaligned)
  );

  // Out-of-range selects fall through to the zero default.
  always_comb begin
    result = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel_q == SEL_W'(k)) begin
        result = (k == LOAD_SRC) ? ld_data : src_data_q[k*XLEN +: XLEN];
      end
    end
  end

  assign misaligned = valid_q && (src_sel_q == SEL_W'(LOAD_SRC)) && ld_misaligned;

  // A stalled instruction retires only on the edge that releases it.
  assign retire = valid_q && !misaligned && !stall_i && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      src_data_q    <= '0;
      src_sel_q     <= '0;
      reg_write_q   <= 1'b0;
      rd_q          <= '0;
      ld_size_q     <= LD_B;
      ld_unsigned_q <= 1'b0;
      ld_addr_lo_q  <= '0;
      instret_q     <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (!stall_i) begin
        valid_q <= mem.valid_i;
        if (mem.valid_i) begin
          src_data_q    <= mem.src_data_i;
          src_sel_q     <= mem.src_sel_i;
          reg_write_q   <= mem.reg_write_i;
          rd_q          <= mem.rd_i;
          ld_size_q     <= mem.ld_size_i;
          ld_unsigned_q <= mem.ld_unsigned_i;
          ld_addr_lo_q  <= mem.ld_addr_lo_i;
        end
      end
      if (retire) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign result_o     = result;
  assign rf_we_o      = valid_q && reg_write_q && (rd_q != '0) && !misaligned;
  assign rf_a3_o      = rd_q;
  assign rf_wd3_o     = result;
  assign fwd_valid_o  = rf_we_o;
  assign fwd_rd_o     = rd_q;
  assign fwd_data_o   = result;
  assign misaligned_o = misaligned;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;
  import core_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;
  localparam int RA_W    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i, stall_i;
  logic [XLEN-1:0] result_o, rf_wd3_o, fwd_data_o;
  logic [RA_W-1:0] rf_a3_o, fwd_rd_o;
  logic            rf_we_o, fwd_valid_o, misaligned_o;
  logic [63:0]     instret_o;

  always #5 clk = ~clk;

  write_back_stage_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RA_W(RA_W)) mem_if ();

  write_back_stage #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .LOAD_SRC(SRC_LOAD), .RA_W(RA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem_if.slave),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .result_o     (result_o),
    .rf_a3_o      (rf_a3_o),
    .rf_wd3_o     (rf_wd3_o),
    .rf_we_o      (rf_we_o),
    .fwd_valid_o  (fwd_valid_o),
    .fwd_rd_o     (fwd_rd_o),
    .fwd_data_o   (fwd_data_o),
    .misaligned_o (misaligned_o),
    .instret_o    (instret_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic            we;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            mis;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_instret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction and push what the stage must show once captured.
  task automatic issue(input int sel, input logic [RA_W-1:0] rd, input logic wr,
                       input logic [XLEN-1:0] word, input ld_size_t size,
                       input logic uns, input logic [2:0] lo,
                       input logic exp_we, input logic [XLEN-1:0] exp_data,
                       input logic exp_mis);
    exp_t e;
    for (int k = 0; k < NUM_SRC; k++) mem_if.src_data_i[k*XLEN +: XLEN] = $urandom;
    mem_if.src_data_i[sel*XLEN +: XLEN] = word;
    mem_if.valid_i       = 1'b1;
    mem_if.src_sel_i     = 2'(sel);
    mem_if.reg_write_i   = wr;
    mem_if.rd_i          = rd;
    mem_if.ld_size_i     = size;
    mem_if.ld_unsigned_i = uns;
    mem_if.ld_addr_lo_i  = lo;
    e.we = exp_we; e.rd = rd; e.data = exp_data; e.mis = exp_mis;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_we"},   64'(rf_we_o),      64'(e.we));
    check({tag, "_fwdv"}, 64'(fwd_valid_o),  64'(e.we));
    check({tag, "_mis"},  64'(misaligned_o), 64'(e.mis));
    check({tag, "_a3"},   64'(rf_a3_o),      64'(e.rd));
    check({tag, "_fwdrd"}, 64'(fwd_rd_o),    64'(e.rd));
    if (!e.mis) begin
      check({tag, "_wd3"},  64'(rf_wd3_o),   64'(e.data));
      check({tag, "_fwdd"}, 64'(fwd_data_o), 64'(e.data));
      exp_instret = exp_instret + 64'd1;
    end
  endtask

  // Single instruction: capture, compare, then a bubble edge retires it.
  task automatic run_one(input string tag, input int sel, input logic [RA_W-1:0] rd,
                         input logic wr, input logic [XLEN-1:0] word, input ld_size_t size,
                         input logic uns, input logic [2:0] lo, input logic exp_we,
                         input logic [XLEN-1:0] exp_data, input logic exp_mis);
    issue(sel, rd, wr, word, size, uns, lo, exp_we, exp_data, exp_mis);
    tick();
    mem_if.valid_i = 1'b0;
    compare_out(tag);
    tick();
    check({tag, "_instret"}, instret_o, exp_instret);
    check({tag, "_bubble_we"}, 64'(rf_we_o), 64'd0);
  endtask

  logic [XLEN-1:0] w;
  logic [RA_W-1:0] r;
  logic [XLEN-1:0] held_data;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    mem_if.valid_i = 1'b0; mem_if.src_data_i = '0; mem_if.src_sel_i = '0;
    mem_if.reg_write_i = 1'b0; mem_if.rd_i = '0; mem_if.ld_size_i = LD_B;
    mem_if.ld_unsigned_i = 1'b0; mem_if.ld_addr_lo_i = '0;
    exp_instret = 64'd0;
    tick(); tick();
    check("rst_we",      64'(rf_we_o),      64'd0);
    check("rst_fwdv",    64'(fwd_valid_o),  64'd0);
    check("rst_mis",     64'(misaligned_o), 64'd0);
    check("rst_instret", instret_o,         64'd0);
    check("rst_result",  64'(result_o),     64'd0);
    check("rst_ready",   64'(mem_if.ready_o), 64'd1);
    rst_n = 1'b1;

    // ALU result, then loads of each size and alignment
    run_one("alu",      SRC_ALU,  5'd5, 1'b1, 32'h0000_1234, LD_B, 1'b0, 3'd0, 1'b1, 32'h0000_1234, 1'b0);
    run_one("lb_s",     SRC_LOAD, 5'd6, 1'b1, 32'h80FF_0000, LD_B, 1'b0, 3'd2, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_one("lb_u",     SRC_LOAD, 5'd6, 1'b1, 32'h80FF_0000, LD_B, 1'b1, 3'd2, 1'b1, 32'h0000_00FF, 1'b0);
    run_one("lb_s3",    SRC_LOAD, 5'd7, 1'b1, 32'h7F12_3456, LD_B, 1'b0, 3'd3, 1'b1, 32'h0000_007F, 1'b0);
    run_one("lb_s1",    SRC_LOAD, 5'd7, 1'b1, 32'h0000_8000, LD_B, 1'b0, 3'd1, 1'b1, 32'hFFFF_FF80, 1'b0);
    run_one("lh_s",     SRC_LOAD, 5'd8, 1'b1, 32'h80FF_0000, LD_H, 1'b0, 3'd2, 1'b1, 32'hFFFF_80FF, 1'b0);
    run_one("lh_u",     SRC_LOAD, 5'd8, 1'b1, 32'h80FF_0000, LD_H, 1'b1, 3'd2, 1'b1, 32'h0000_80FF, 1'b0);
    run_one("lw",       SRC_LOAD, 5'd9, 1'b1, 32'h8000_0001, LD_W, 1'b0, 3'd0, 1'b1, 32'h8000_0001, 1'b0);
    run_one("lw_u",     SRC_LOAD, 5'd9, 1'b1, 32'h8000_0001, LD_W, 1'b1, 3'd4, 1'b1, 32'h8000_0001, 1'b0);
    run_one("lh_mis",   SRC_LOAD, 5'd10, 1'b1, 32'h1234_5678, LD_H, 1'b0, 3'd1, 1'b0, 32'h0, 1'b1);
    run_one("lw_mis",   SRC_LOAD, 5'd11, 1'b1, 32'h1234_5678, LD_W, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1);
    run_one("alu_nomis", SRC_ALU, 5'd12, 1'b1, 32'hCAFE_F00D, LD_H, 1'b0, 3'd1, 1'b1, 32'hCAFE_F00D, 1'b0);
    run_one("x0",       SRC_ALU,  5'd0, 1'b1, 32'h0000_0055, LD_B, 1'b0, 3'd0, 1'b0, 32'h0000_0055, 1'b0);
    run_one("nowr",     SRC_CSR,  5'd3, 1'b0, 32'h0000_0077, LD_B, 1'b0, 3'd0, 1'b0, 32'h0000_0077, 1'b0);

    // Random pass-through on non-load sources
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      r = 5'($urandom_range(1, 31));
      run_one("rnd", (i % 2 == 0) ? SRC_CSR : 3, r, 1'b1, w, LD_H, 1'b0, 3'd1, 1'b1, w, 1'b0);
    end

    // Stall: hold three cycles, new input must not be taken, one retirement on release
    issue(SRC_ALU, 5'd14, 1'b1, 32'hABCD_0001, LD_B, 1'b0, 3'd0, 1'b1, 32'hABCD_0001, 1'b0);
    tick();
    compare_out("stall_cap");
    held_data = 32'hABCD_0001;
    stall_i = 1'b1;
    mem_if.rd_i = 5'd20;
    mem_if.src_data_i = '1;
    #1;
    check("stall_ready", 64'(mem_if.ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_we",      64'(rf_we_o),  64'd1);
      check("stall_a3",      64'(rf_a3_o),  64'd14);
      check("stall_wd3",     64'(rf_wd3_o), 64'(held_data));
      check("stall_instret", instret_o,     exp_instret - 64'd1);
    end
    stall_i = 1'b0;
    mem_if.valid_i = 1'b0;
    tick();
    check("stall_rel_instret", instret_o, exp_instret);
    check("stall_rel_we", 64'(rf_we_o), 64'd0);

    // Flush with valid and stall: registered instruction killed, not counted
    issue(SRC_ALU, 5'd15, 1'b1, 32'h0000_0F0F, LD_B, 1'b0, 3'd0, 1'b1, 32'h0000_0F0F, 1'b0);
    tick();
    compare_out("flush_cap");
    exp_instret = exp_instret - 64'd1;
    void'(sb.size());
    issue(SRC_ALU, 5'd16, 1'b1, 32'h0000_1111, LD_B, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    void'(sb.pop_back());
    flush_i = 1'b1; stall_i = 1'b1;
    tick();
    check("flush_we",      64'(rf_we_o),      64'd0);
    check("flush_fwdv",    64'(fwd_valid_o),  64'd0);
    check("flush_instret", instret_o,         exp_instret);
    flush_i = 1'b0; stall_i = 1'b0; mem_if.valid_i = 1'b0;
    tick();
    check("flush_after_instret", instret_o, exp_instret);

    // Reset during a stall clears everything
    issue(SRC_ALU, 5'd17, 1'b1, 32'h0000_2222, LD_B, 1'b0, 3'd0, 1'b1, 32'h0000_2222, 1'b0);
    tick();
    compare_out("rststall_cap");
    mem_if.valid_i = 1'b0;
    stall_i = 1'b1; rst_n = 1'b0;
    tick();
    check("rststall_we",      64'(rf_we_o), 64'd0);
    check("rststall_instret", instret_o,    64'd0);
    exp_instret = 64'd0;
    stall_i = 1'b0; rst_n = 1'b1;

    // Counter wrap
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(SRC_ALU, 5'd18, 1'b1, 32'h0000_0001, LD_B, 1'b0, 3'd0, 1'b1, 32'h0000_0001, 1'b0);
    tick();
    compare_out("wrap1");
    issue(SRC_ALU, 5'd19, 1'b1, 32'h0000_0002, LD_B, 1'b0, 3'd0, 1'b1, 32'h0000_0002, 1'b0);
    tick();
    check("wrap_mid", instret_o, 64'd0);
    compare_out("wrap2");
    mem_if.valid_i = 1'b0;
    tick();
    check("wrap_instret", instret_o, 64'd1);
    check("wrap_model",   instret_o, exp_instret);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
